// File: rtl/hazard_pkg.sv
// Shared definitions for the scoreboard-style hazard tracker: default widths,
// the hard-wired zero register and the default-width pipeline entry layout.
package hazard_pkg;

  localparam int DEF_DEPTH  = 3;
  localparam int DEF_TNEW_W = 2;
  localparam int DEF_REG_W  = 5;
  localparam int DEF_CNT_W  = 16;

  localparam logic [DEF_REG_W-1:0] REG_ZERO = '0;

  // Entry layout at the default widths; the tracker builds the same layout
  // at its own parameter widths.
  typedef struct packed {
    logic                  valid;
    logic                  wen;
    logic [DEF_REG_W-1:0]  dst;
    logic [DEF_TNEW_W-1:0] tnew;
  } entry_t;

endpackage

// File: rtl/hazard_match.sv
// Compares one D-stage source against every tracked entry; the youngest
// matching producer decides both the stall request and the forwarding select.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int TNEW_W = DEF_TNEW_W,
  parameter int REG_W  = DEF_REG_W,
  parameter int SEL_W  = $clog2(DEPTH + 1)
) (
  input  logic                         used_i,
  input  logic [REG_W-1:0]             reg_i,
  input  logic [TNEW_W-1:0]            tuse_i,
  input  logic [DEPTH-1:0]             valid_i,
  input  logic [DEPTH-1:0]             wen_i,
  input  logic [DEPTH-1:0][REG_W-1:0]  dst_i,
  input  logic [DEPTH-1:0][TNEW_W-1:0] tnew_i,
  output logic                         stall_o,
  output logic [SEL_W-1:0]             sel_o
);

  logic [DEPTH-1:0] hit;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit[i] = used_i && (reg_i != REG_W'(REG_ZERO)) &&
               valid_i[i] && wen_i[i] && (dst_i[i] == reg_i);
    end
  end

  // Scan oldest to youngest so the lowest-index hit is the one that sticks.
  always_comb begin
    stall_o = 1'b0;
    sel_o   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (hit[i]) begin
        stall_o = tnew_i[i] > tuse_i;
        sel_o   = SEL_W'(i + 1);
      end
    end
  end

endmodule

// File: rtl/hazard_tracker.sv
// Tracks in-flight producers behind D, raises a load-use style stall and
// selects forwarding sources for rs/rt; counts stall cycles with saturation.
module hazard_tracker
  import hazard_pkg::*;
#(
  parameter  int DEPTH  = DEF_DEPTH,
  parameter  int TNEW_W = DEF_TNEW_W,
  parameter  int REG_W  = DEF_REG_W,
  parameter  int CNT_W  = DEF_CNT_W,
  localparam int SEL_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d_valid,
  input  logic [REG_W-1:0]  d_rs,
  input  logic [REG_W-1:0]  d_rt,
  input  logic              d_rs_used,
  input  logic              d_rt_used,
  input  logic [TNEW_W-1:0] d_rs_tuse,
  input  logic [TNEW_W-1:0] d_rt_tuse,
  input  logic [REG_W-1:0]  d_dst,
  input  logic              d_wen,
  input  logic [TNEW_W-1:0] d_tnew,
  input  logic              flush,
  output logic              stall,
  output logic [SEL_W-1:0]  fwd_rs_sel,
  output logic [SEL_W-1:0]  fwd_rt_sel,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic              valid;
    logic              wen;
    logic [REG_W-1:0]  dst;
    logic [TNEW_W-1:0] tnew;
  } stage_t;

  stage_t [DEPTH-1:0] pipe_q, pipe_d;
  logic   [CNT_W-1:0] cnt_q, cnt_d;

  logic [DEPTH-1:0]             valid_v, wen_v;
  logic [DEPTH-1:0][REG_W-1:0]  dst_v;
  logic [DEPTH-1:0][TNEW_W-1:0] tnew_v;
  logic                         stall_rs, stall_rt;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      valid_v[i] = pipe_q[i].valid;
      wen_v[i]   = pipe_q[i].wen;
      dst_v[i]   = pipe_q[i].dst;
      tnew_v[i]  = pipe_q[i].tnew;
    end
  end

  hazard_match #(.DEPTH(DEPTH), .TNEW_W(TNEW_W), .REG_W(REG_W), .SEL_W(SEL_W)) u_match_rs (
    .used_i (d_rs_used),
    .reg_i  (d_rs),
    .tuse_i (d_rs_tuse),
    .valid_i(valid_v),
    .wen_i  (wen_v),
    .dst_i  (dst_v),
    .tnew_i (tnew_v),
    .stall_o(stall_rs),
    .sel_o  (fwd_rs_sel)
  );

  hazard_match #(.DEPTH(DEPTH), .TNEW_W(TNEW_W), .REG_W(REG_W), .SEL_W(SEL_W)) u_match_rt (
    .used_i (d_rt_used),
    .reg_i  (d_rt),
    .tuse_i (d_rt_tuse),
    .valid_i(valid_v),
    .wen_i  (wen_v),
    .dst_i  (dst_v),
    .tnew_i (tnew_v),
    .stall_o(stall_rt),
    .sel_o  (fwd_rt_sel)
  );

  assign stall     = d_valid & (stall_rs | stall_rt);
  assign stall_cnt = cnt_q;

  // A stalled or flushed D slot enters E as a bubble; older entries age by one.
  always_comb begin
    pipe_d    = '0;
    if (d_valid && !stall && !flush) begin
      pipe_d[0].valid = 1'b1;
      pipe_d[0].wen   = d_wen;
      pipe_d[0].dst   = d_dst;
      pipe_d[0].tnew  = d_tnew;
    end
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i]      = pipe_q[i-1];
      pipe_d[i].tnew = (pipe_q[i-1].tnew != '0) ? pipe_q[i-1].tnew - TNEW_W'(1) : '0;
    end
    cnt_d = (stall && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // NOTE: sequential state uses non-blocking assignments only; the small
  // entry array is reset too, since a stale valid bit would fake a hazard.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_q <= '0;
      cnt_q  <= '0;
    end else begin
      pipe_q <= pipe_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_tracker.sv
// Self-checking bench: directed pipeline scenarios plus random D traffic,
// compared against an age-based model of in-flight producers.
module tb_hazard_tracker;

  localparam int DEPTH   = 3;
  localparam int TNEW_W  = 2;
  localparam int REG_W   = 5;
  localparam int SEL_W   = 2;
  localparam int CNT_MAX = 65535;
  localparam int SAT_MAX = 63;

  logic              clk = 1'b0;
  logic              reset;
  logic              d_valid, d_rs_used, d_rt_used, d_wen, flush;
  logic [REG_W-1:0]  d_rs, d_rt, d_dst;
  logic [TNEW_W-1:0] d_rs_tuse, d_rt_tuse, d_tnew;
  logic              stall, stall_s;
  logic [SEL_W-1:0]  fwd_rs_sel, fwd_rt_sel, fwd_rs_s, fwd_rt_s;
  logic [15:0]       stall_cnt;
  logic [5:0]        stall_cnt_s;

  always #5 clk = ~clk;

  hazard_tracker dut (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
    .d_rs_used(d_rs_used), .d_rt_used(d_rt_used), .d_rs_tuse(d_rs_tuse),
    .d_rt_tuse(d_rt_tuse), .d_dst(d_dst), .d_wen(d_wen), .d_tnew(d_tnew),
    .flush(flush), .stall(stall), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
    .stall_cnt(stall_cnt)
  );

  // Narrow-counter copy on the same inputs so saturation is reachable quickly.
  hazard_tracker #(.CNT_W(6)) dut_sat (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
    .d_rs_used(d_rs_used), .d_rt_used(d_rt_used), .d_rs_tuse(d_rs_tuse),
    .d_rt_tuse(d_rt_tuse), .d_dst(d_dst), .d_wen(d_wen), .d_tnew(d_tnew),
    .flush(flush), .stall(stall_s), .fwd_rs_sel(fwd_rs_s), .fwd_rt_sel(fwd_rt_s),
    .stall_cnt(stall_cnt_s)
  );

  typedef struct {
    bit valid;
    bit wen;
    int dst;
    int tnew;
  } slot_t;

  slot_t hist[DEPTH];      // hist[a]: instruction that entered E a edges ago
  int    cnt_model;
  int    n_checks = 0;
  int    n_fail   = 0;

  bit cur_v, cur_rsu, cur_rtu, cur_wen, cur_fl;
  int cur_rs, cur_rt, cur_rs_tu, cur_rt_tu, cur_dst, cur_tnew;
  bit exp_stall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int a = 0; a < DEPTH; a++) hist[a] = '{0, 0, 0, 0};
    cnt_model = 0;
  endtask

  // Remaining latency of a producer is its issue-time tnew minus its age.
  function automatic void model_src(input bit used, input int r, input int tuse,
                                    output bit st, output int sel);
    st  = 0;
    sel = 0;
    if (used && r != 0) begin
      for (int a = 0; a < DEPTH; a++) begin
        if (hist[a].valid && hist[a].wen && hist[a].dst == r) begin
          int rem;
          rem = hist[a].tnew - a;
          if (rem < 0) rem = 0;
          st  = rem > tuse;
          sel = a + 1;
          break;
        end
      end
    end
  endfunction

  task automatic drive(input bit v, input int rs, input bit rsu, input int rs_tu,
                       input int rt, input bit rtu, input int rt_tu,
                       input int dst, input bit wen, input int tnew, input bit fl);
    cur_v = v; cur_rs = rs; cur_rsu = rsu; cur_rs_tu = rs_tu;
    cur_rt = rt; cur_rtu = rtu; cur_rt_tu = rt_tu;
    cur_dst = dst; cur_wen = wen; cur_tnew = tnew; cur_fl = fl;
    d_valid = v; d_rs = 5'(rs); d_rs_used = rsu; d_rs_tuse = 2'(rs_tu);
    d_rt = 5'(rt); d_rt_used = rtu; d_rt_tuse = 2'(rt_tu);
    d_dst = 5'(dst); d_wen = wen; d_tnew = 2'(tnew); flush = fl;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic settle_and_check();
    bit srs, srt;
    int sel_rs, sel_rt;
    #1;
    model_src(cur_rsu, cur_rs, cur_rs_tu, srs, sel_rs);
    model_src(cur_rtu, cur_rt, cur_rt_tu, srt, sel_rt);
    exp_stall = cur_v && (srs || srt);
    check("stall", 32'(stall), 32'(exp_stall));
    check("fwd_rs_sel", 32'(fwd_rs_sel), sel_rs);
    check("fwd_rt_sel", 32'(fwd_rt_sel), sel_rt);
  endtask

  task automatic tick();
    bit issue;
    issue = cur_v && !exp_stall && !cur_fl;
    @(posedge clk);
    for (int a = DEPTH - 1; a > 0; a--) hist[a] = hist[a-1];
    hist[0] = issue ? '{1, cur_wen, cur_dst, cur_tnew} : '{0, 0, 0, 0};
    if (exp_stall) cnt_model++;
    #1;
    check("stall_cnt", 32'(stall_cnt), (cnt_model > CNT_MAX) ? CNT_MAX : cnt_model);
    check("stall_cnt_sat", 32'(stall_cnt_s), (cnt_model > SAT_MAX) ? SAT_MAX : cnt_model);
  endtask

  task automatic step();
    settle_and_check();
    tick();
  endtask

  task automatic drain();
    idle();
    repeat (DEPTH + 1) step();
  endtask

  initial begin
    reset = 1'b1;
    drive(1, 8, 1, 0, 8, 1, 0, 8, 1, 3, 0);
    #2;
    check("rst_stall", 32'(stall), 0);
    check("rst_fwd_rs", 32'(fwd_rs_sel), 0);
    check("rst_fwd_rt", 32'(fwd_rt_sel), 0);
    check("rst_cnt", 32'(stall_cnt), 0);
    #5;
    check("rst_stall_after_edge", 32'(stall), 0);
    idle();
    #5 reset = 1'b0;
    @(posedge clk); #1;
    model_clear();

    // lw $8 (tnew 2) then add rs=$8 (tuse 1)
    drive(1, 0, 0, 0, 0, 0, 0, 8, 1, 2, 0); step();
    drive(1, 8, 1, 1, 0, 0, 0, 10, 1, 1, 0); settle_and_check();
    check("lw_add_stall_c1", 32'(stall), 1);
    tick(); settle_and_check();
    check("lw_add_stall_c2", 32'(stall), 0);
    check("lw_add_fwd_rs", 32'(fwd_rs_sel), 2);
    tick();
    check("lw_add_cnt", 32'(stall_cnt), 1);
    drain();

    // add $9 (tnew 1) then beq rs=$9 (tuse 0)
    drive(1, 0, 0, 0, 0, 0, 0, 9, 1, 1, 0); step();
    drive(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0); settle_and_check();
    check("add_beq_stall_c1", 32'(stall), 1);
    tick(); settle_and_check();
    check("add_beq_stall_c2", 32'(stall), 0);
    check("add_beq_fwd_rs", 32'(fwd_rs_sel), 2);
    tick();
    drain();

    // lw $0 then add rs=$0
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0); step();
    drive(1, 0, 1, 0, 0, 0, 0, 11, 1, 1, 0); settle_and_check();
    check("zero_reg_stall", 32'(stall), 0);
    check("zero_reg_fwd", 32'(fwd_rs_sel), 0);
    tick();
    drain();

    // ori $5 (tnew 1), lw $5 (tnew 2), sw rt=$5 (tuse 2)
    drive(1, 0, 0, 0, 0, 0, 0, 5, 1, 1, 0); step();
    drive(1, 0, 0, 0, 0, 0, 0, 5, 1, 2, 0); step();
    drive(1, 0, 0, 0, 5, 1, 2, 0, 0, 0, 0); settle_and_check();
    check("youngest_stall", 32'(stall), 0);
    check("youngest_fwd_rt", 32'(fwd_rt_sel), 1);
    tick();
    drain();

    // stall and flush in the same cycle
    drive(1, 0, 0, 0, 0, 0, 0, 8, 1, 2, 0); step();
    drive(1, 8, 1, 0, 0, 0, 0, 12, 1, 1, 1); settle_and_check();
    check("flush_stall", 32'(stall), 1);
    tick();
    drain();

    // reset during a stall caused by lw $8
    drive(1, 0, 0, 0, 0, 0, 0, 8, 1, 2, 0); step();
    drive(1, 8, 1, 0, 0, 0, 0, 12, 1, 1, 0); settle_and_check();
    check("pre_reset_stall", 32'(stall), 1);
    reset = 1'b1;
    #1;
    check("mid_reset_stall", 32'(stall), 0);
    check("mid_reset_fwd_rs", 32'(fwd_rs_sel), 0);
    check("mid_reset_cnt", 32'(stall_cnt), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
    drive(1, 8, 1, 0, 0, 0, 0, 12, 1, 1, 0); settle_and_check();
    check("post_reset_stall", 32'(stall), 0);
    check("post_reset_fwd_rs", 32'(fwd_rs_sel), 0);
    tick();
    drain();

    // random traffic over a small register window to provoke hazards
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(9, 0) != 0,
            $urandom_range(3, 0), 1'($urandom), $urandom_range(3, 0),
            $urandom_range(3, 0), 1'($urandom), $urandom_range(3, 0),
            $urandom_range(3, 0), 1'($urandom), $urandom_range(3, 0),
            $urandom_range(9, 0) == 0);
      step();
    end
    drain();

    // back-to-back dependent producers push the narrow counter into saturation
    for (int n = 0; n < 120; n++) begin
      drive(1, 8, 1, 0, 0, 0, 0, 8, 1, 3, 0);
      step();
    end
    check("sat_hold", 32'(stall_cnt_s), SAT_MAX);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_tracker.md
HAZARD_TRACKER -- requirements
Module: hazard_tracker

Interface
REQ-001 Parameter DEPTH, default 3; number of tracked stages after D (entry 0 = E, 1 = M, 2 = W).
REQ-002 Parameter TNEW_W, default 2; width of Tuse/Tnew fields.
REQ-003 Parameter REG_W, default 5; register index width.
REQ-004 Parameter CNT_W, default 16; stall counter width.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 d_valid  in  1  D stage holds a real instruction.
REQ-008 d_rs, d_rt  in  REG_W each  D source registers.
REQ-009 d_rs_used, d_rt_used  in  1 each  source actually read.
REQ-010 d_rs_tuse, d_rt_tuse  in  TNEW_W each  cycles until the source value is consumed.
REQ-011 d_dst  in  REG_W  D destination register.
REQ-012 d_wen  in  1  D instruction writes d_dst.
REQ-013 d_tnew  in  TNEW_W  cycles after entering E until the result is available.
REQ-014 flush  in  1  forces a bubble into entry 0 this cycle.
REQ-015 stall  out  1  freeze F/D; insert a bubble into E.
REQ-016 fwd_rs_sel, fwd_rt_sel  out  $clog2(DEPTH+1) each  0 = register file; k = entry k-1.
REQ-017 stall_cnt  out  CNT_W  saturating count of stall cycles.

Function
REQ-018 Each entry holds {valid, wen, dst, tnew}.
REQ-019 Every clock edge, entry[i+1] SHALL load entry[i], with tnew decremented and saturating at 0.
REQ-020 Entry 0 SHALL load {1, d_wen, d_dst, d_tnew} when d_valid & ~stall & ~flush; otherwise it SHALL load a bubble (valid = 0, tnew = 0).
REQ-021 The oldest entry is discarded on shift; no wrap-around.
REQ-022 A source matches entry i when used=1, reg≠0, and entry i has valid & wen & dst==reg.
REQ-023 Only the youngest matching entry (lowest index) counts; older matches are ignored.
REQ-024 Per source, stall_src = 1 iff a youngest match exists with tnew > tuse.
REQ-025 stall = d_valid & (stall_rs | stall_rt); it is combinational from current state and D inputs; latency 0.
REQ-026 fwd_*_sel = (index of youngest match)+1, else 0; it is driven even while stalling.
REQ-027 A register index of 0 SHALL never stall and never forward.
REQ-028 flush and stall together: the bubble is inserted once; stall_cnt still increments.
REQ-029 stall_cnt increments on each edge where stall=1 and holds at 2^CNT_W-1.

Reset
REQ-030 On reset assertion, all entries SHALL become immediately invalid with tnew=0, and stall_cnt=0.
REQ-031 While reset is asserted, stall=0, fwd_rs_sel=0 and fwd_rt_sel=0, regardless of D inputs.
REQ-032 Reset mid-stall SHALL drop all in-flight producers; the first cycle after release sees an empty tracker.

Structure
REQ-033 Package hazard_pkg SHALL hold the entry typedef, REG_ZERO, and default TNEW_W/REG_W.
REQ-034 Sub-module hazard_match (one source vs all entries → stall_src, fwd_sel) SHALL be instantiated twice, for rs and rt.

Verification
REQ-035 lw $8 (tnew=2), then add rs=$8 (tuse=1) → cycle 1: stall=1; cycle 2: stall=0, fwd_rs_sel=2; stall_cnt=1.
REQ-036 add $9 (tnew=1), then beq rs=$9 (tuse=0) → one stall cycle, then fwd_rs_sel=2.
REQ-037 lw $0, then add rs=$0 → stall=0, fwd_rs_sel=0.
REQ-038 ori $5 (tnew=1), then lw $5 (tnew=2), then sw rt=$5 (tuse=2) → no stall, fwd_rt_sel=1 (youngest match).
REQ-039 Assert reset during a stall caused by lw $8 → stall drops immediately; after release, add rs=$8 gives stall=0, fwd_rs_sel=0.
REQ-040 Hold a stall for 70000 cycles (CNT_W=16) → stall_cnt=16'hFFFF and holds.
